rename_dispatch_ctrl: RTL and testbench
=======================================

# rename_dispatch_ctrl

Sequencer for the register-rename map table. Each cycle it decides whether the decoded instruction group may be renamed and dispatched. It allocates the ROB indices the map table uses to checkpoint itself. On a branch mispredict it drives the single-cycle rollback pulse, then holds dispatch off while the ROB, free list and RS recover. It sits between decode, the map table, the free list, the ROB and the RS.

## Interface
Parameters:
- NUM_SUPER, 2, dispatch width; every group is all-or-nothing.
- NUM_ROB, 32, ROB entries; a power of two.
- RECOVER_CYCLES, 2, dispatch-blocked cycles after a rollback pulse; range 1..15.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- inst_valid  in  NUM_SUPER  decoder slot valid.
- ROB_free_cnt  in  $clog2(NUM_ROB)+1  free ROB entries.
- FL_free_cnt  in  8  free physical registers.
- RS_free_cnt  in  8  free RS entries.
- ROB_head_idx  in  $clog2(NUM_ROB)  oldest ROB entry; used for age compares.
- mispredict  in  1  branch mispredict request.
- mispredict_idx  in  $clog2(NUM_ROB)  ROB index of the mispredicted branch.
- dispatch_en  out  1  rename/dispatch the whole group this cycle.
- ROB_idx  out  NUM_SUPER x $clog2(NUM_ROB)  per-slot ROB index; ROB_idx[j] = tail + j, mod NUM_ROB.
- rollback_en  out  1  map table restore pulse.
- ROB_rollback_idx  out  $clog2(NUM_ROB)  checkpoint index to restore from.
- stall  out  1  freeze fetch/decode; equals valid group present and !dispatch_en.

## Operation
- States: RUN, ROLLBACK, RECOVER. A 4-bit recover counter `rc` and a $clog2(NUM_ROB)-bit `tail` are also held.
- dispatch_en is asserted when all of the following hold:
  - state is RUN;
  - all inst_valid bits are set;
  - ROB_free_cnt, FL_free_cnt and RS_free_cnt are each ≥ NUM_SUPER;
  - mispredict is low.
- dispatch_en is combinational from the current state and inputs.
- On dispatch_en, tail advances by NUM_SUPER, modulo NUM_ROB.
- RUN with mispredict:
  - latch mispredict_idx into ROB_rollback_idx;
  - next state is ROLLBACK;
  - no dispatch in this cycle.
- ROLLBACK:
  - rollback_en = 1 for exactly one cycle;
  - tail <= ROB_rollback_idx + 1;
  - rc <= RECOVER_CYCLES;
  - next state is RECOVER.
- RECOVER:
  - rc decrements each cycle;
  - when rc == 1, next state is RUN.
- Age is defined as (idx − ROB_head_idx) mod NUM_ROB.
- A mispredict arriving in ROLLBACK or RECOVER is handled by age:
  - if it is strictly older than the latched index, latch the new index and go to ROLLBACK next (a second pulse follows);
  - otherwise it is dropped;
  - a mispredict with the same index is dropped.
- A mispredict arriving in the same cycle as a ROLLBACK pulse follows the same age rule.
- stall = |inst_valid & !dispatch_en.

## Timing
- Reset values:
  - state = RUN, tail = 0, rc = 0;
  - rollback_en = 0, ROB_rollback_idx = 0;
  - dispatch_en = 0 (no valid input), stall = 0.
- Reset asserted mid-rollback aborts it: no pulse is issued after the reset cycle.
- Mispredict accepted in cycle t:
  - rollback_en is high in t+1;
  - dispatch is blocked in t through t+1+RECOVER_CYCLES;
  - dispatch is first possible in t+2+RECOVER_CYCLES.
- rollback_en and ROB_rollback_idx are registered. ROB_idx is registered tail plus constant offsets.
- Wrap-around: tail = NUM_ROB−1 with NUM_SUPER = 2 gives ROB_idx = {0, NUM_ROB−1} (slot1, slot0).
- A resource count exactly equal to NUM_SUPER permits dispatch; NUM_SUPER−1 blocks it.

## Configuration
- DISPATCH_STATS_EN defined:
  - adds 32-bit outputs stall_cycles and rollback_cnt;
  - both reset to 0 and saturate at all-ones;
  - stall_cycles increments on each cycle with stall = 1;
  - rollback_cnt increments on each rollback_en pulse.
- DISPATCH_STATS_EN undefined: neither the ports nor the counters exist; all other behaviour is identical.

## Test plan
- Reset, then both slots valid with all counts = 8 for 3 cycles -> dispatch_en = 1 each cycle; ROB_idx = {1,0}, {3,2}, {5,4}; stall = 0.
- FL_free_cnt = 1 with both slots valid -> dispatch_en = 0, stall = 1, tail unchanged. Raising FL_free_cnt to 2 makes dispatch_en = 1 in the same cycle.
- tail = 30, then mispredict with idx 12 in cycle t -> rollback_en = 1 only in t+1 with ROB_rollback_idx = 12; dispatch blocked through t+3 (RECOVER_CYCLES = 2); dispatch in t+4 gives ROB_idx = {14,13}.
- Head = 10, mispredict idx 20 in cycle t, then idx 15 in t+2 (older) -> second rollback pulse in t+3 with idx 15. A further mispredict with idx 25 in t+4 (younger) is ignored.
- tail = 31 with a dispatch -> ROB_idx = {0,31}, and tail becomes 1 (wraps).
- Reset asserted in the ROLLBACK cycle -> next cycle shows state RUN, rollback_en = 0, tail = 0. With DISPATCH_STATS_EN, rollback_cnt = 0.

Source files
------------

// File: rtl/rename_dispatch_ctrl.sv
// rtl/rename_dispatch_ctrl.sv - rename/dispatch sequencer with mispredict rollback and recovery
// Optional DISPATCH_STATS_EN adds saturating stall_cycles / rollback_cnt counters.
module rename_dispatch_ctrl #(
  parameter int NUM_SUPER      = 2,
  parameter int NUM_ROB        = 32,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [NUM_SUPER-1:0]                          inst_valid,
  input  logic [$clog2(NUM_ROB):0]                      ROB_free_cnt,
  input  logic [7:0]                                    FL_free_cnt,
  input  logic [7:0]                                    RS_free_cnt,
  input  logic [$clog2(NUM_ROB)-1:0]                    ROB_head_idx,
  input  logic                                          mispredict,
  input  logic [$clog2(NUM_ROB)-1:0]                    mispredict_idx,
  output logic                                          dispatch_en,
  output logic [NUM_SUPER-1:0][$clog2(NUM_ROB)-1:0]     ROB_idx,
  output logic                                          rollback_en,
  output logic [$clog2(NUM_ROB)-1:0]                    ROB_rollback_idx,
  output logic                                          stall
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                                   stall_cycles,
  output logic [31:0]                                   rollback_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_ROB);
  localparam logic [IDX_W:0]   NS_ROB = (IDX_W+1)'(NUM_SUPER);
  localparam logic [7:0]       NS_8   = 8'(NUM_SUPER);
  localparam logic [IDX_W-1:0] NS_IDX = IDX_W'(NUM_SUPER);
  localparam logic [3:0]       RC_INIT = 4'(RECOVER_CYCLES);

  typedef enum logic [1:0] {RUN, ROLLBACK, RECOVER} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] tail;
  logic [3:0]       rc;
  logic [IDX_W-1:0] age_new, age_cur;
  logic             older, res_ok, accept;

  // Ages are distances from the ROB head, so a smaller age is an older instruction.
  assign age_new = mispredict_idx - ROB_head_idx;
  assign age_cur = ROB_rollback_idx - ROB_head_idx;
  assign older   = age_new < age_cur;

  assign res_ok = (ROB_free_cnt >= NS_ROB) && (FL_free_cnt >= NS_8) && (RS_free_cnt >= NS_8);

  always_comb begin
    state_next  = state;
    dispatch_en = 1'b0;
    accept      = 1'b0;
    case (state)
      RUN: begin
        if (mispredict) begin
          accept     = 1'b1;
          state_next = ROLLBACK;
        end else if (&inst_valid && res_ok) begin
          dispatch_en = 1'b1;
        end
      end
      ROLLBACK: begin
        state_next = RECOVER;
        if (mispredict && older) begin
          accept     = 1'b1;
          state_next = ROLLBACK;
        end
      end
      RECOVER: begin
        if (rc == 4'd1) state_next = RUN;
        if (mispredict && older) begin
          accept     = 1'b1;
          state_next = ROLLBACK;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign stall = (|inst_valid) && !dispatch_en;

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tail             <= '0;
      rc               <= '0;
      rollback_en      <= 1'b0;
      ROB_rollback_idx <= '0;
    end else begin
      rollback_en <= (state_next == ROLLBACK);
      if (accept) ROB_rollback_idx <= mispredict_idx;
      // The branch itself survives the rollback, so allocation resumes just after it.
      if (state == ROLLBACK) begin
        tail <= ROB_rollback_idx + IDX_W'(1);
        rc   <= RC_INIT;
      end else begin
        if (dispatch_en) tail <= tail + NS_IDX;
        if (state == RECOVER && rc != 4'd0) rc <= rc - 4'd1;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_SUPER; j++) begin
      ROB_idx[j] = tail + IDX_W'(j);
    end
  end

`ifdef DISPATCH_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      rollback_cnt <= '0;
    end else begin
      if (stall && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
      if (rollback_en && rollback_cnt != 32'hFFFF_FFFF) rollback_cnt <= rollback_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rename_dispatch_ctrl.sv
// tb/tb_rename_dispatch_ctrl.sv - scoreboard bench for rename_dispatch_ctrl
module tb_rename_dispatch_ctrl;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       inst_valid;
  logic [5:0]       ROB_free_cnt;
  logic [7:0]       FL_free_cnt;
  logic [7:0]       RS_free_cnt;
  logic [4:0]       ROB_head_idx;
  logic             mispredict;
  logic [4:0]       mispredict_idx;
  logic             dispatch_en;
  logic [1:0][4:0]  ROB_idx;
  logic             rollback_en;
  logic [4:0]       ROB_rollback_idx;
  logic             stall;
`ifdef DISPATCH_STATS_EN
  logic [31:0]      stall_cycles;
  logic [31:0]      rollback_cnt;
`endif

  rename_dispatch_ctrl #(.NUM_SUPER(2), .NUM_ROB(32), .RECOVER_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .inst_valid(inst_valid),
    .ROB_free_cnt(ROB_free_cnt), .FL_free_cnt(FL_free_cnt), .RS_free_cnt(RS_free_cnt),
    .ROB_head_idx(ROB_head_idx), .mispredict(mispredict), .mispredict_idx(mispredict_idx),
    .dispatch_en(dispatch_en), .ROB_idx(ROB_idx), .rollback_en(rollback_en),
    .ROB_rollback_idx(ROB_rollback_idx), .stall(stall)
`ifdef DISPATCH_STATS_EN
    , .stall_cycles(stall_cycles), .rollback_cnt(rollback_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       disp;
    logic       stl;
    logic       rb_en;
    logic [4:0] rb_idx;
    logic [9:0] rob_idx;
    logic [31:0] st_cyc;
    logic [31:0] rb_cnt;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: m_left counts the cycles still blocked after an accepted mispredict.
  localparam int RC = 2;
  logic [4:0]  m_tail, m_rb_idx;
  int          m_left;
  logic [31:0] m_st_cyc, m_rb_cnt;

  logic       d_rst, d_mis;
  logic [1:0] d_valid;
  logic [5:0] d_rob;
  logic [7:0] d_fl, d_rs;
  logic [4:0] d_head, d_midx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    exp_t e, g;
    logic run, pulse, acc;
    logic [4:0] age_n, age_c;
    @(posedge clock);
    #1;
    reset = d_rst; inst_valid = d_valid; ROB_free_cnt = d_rob; FL_free_cnt = d_fl;
    RS_free_cnt = d_rs; ROB_head_idx = d_head; mispredict = d_mis; mispredict_idx = d_midx;
    run   = (m_left == 0);
    pulse = (m_left == RC + 1);
    e.disp    = run && (d_valid == 2'b11) && d_rob >= 6'd2 && d_fl >= 8'd2 && d_rs >= 8'd2 && !d_mis;
    e.stl     = (d_valid != 2'b00) && !e.disp;
    e.rb_en   = pulse;
    e.rb_idx  = m_rb_idx;
    e.rob_idx = {m_tail + 5'd1, m_tail};
    e.st_cyc  = m_st_cyc;
    e.rb_cnt  = m_rb_cnt;
    sb.push_back(e);
    @(negedge clock);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      check("dispatch_en", {31'd0, dispatch_en}, {31'd0, g.disp});
      check("stall", {31'd0, stall}, {31'd0, g.stl});
      check("rollback_en", {31'd0, rollback_en}, {31'd0, g.rb_en});
      check("ROB_rollback_idx", {27'd0, ROB_rollback_idx}, {27'd0, g.rb_idx});
      check("ROB_idx", {22'd0, ROB_idx[1], ROB_idx[0]}, {22'd0, g.rob_idx});
`ifdef DISPATCH_STATS_EN
      check("stall_cycles", stall_cycles, g.st_cyc);
      check("rollback_cnt", rollback_cnt, g.rb_cnt);
`endif
    end
    age_n = d_midx - d_head;
    age_c = m_rb_idx - d_head;
    acc   = d_mis && (run || age_n < age_c);
    if (d_rst) begin
      m_tail = 0; m_rb_idx = 0; m_left = 0; m_st_cyc = 0; m_rb_cnt = 0;
    end else begin
      if (e.stl && m_st_cyc != 32'hFFFF_FFFF) m_st_cyc++;
      if (pulse && m_rb_cnt != 32'hFFFF_FFFF) m_rb_cnt++;
      if (pulse) m_tail = m_rb_idx + 5'd1;
      else if (e.disp) m_tail = m_tail + 5'd2;
      if (acc) begin
        m_rb_idx = d_midx;
        m_left   = RC + 1;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
    d_rst = 1'b0;
    d_mis = 1'b0;
  endtask

  task automatic full_res();
    d_rob = 6'd8; d_fl = 8'd8; d_rs = 8'd8;
  endtask

  initial begin
    reset = 1'b1; inst_valid = 0; ROB_free_cnt = 0; FL_free_cnt = 0; RS_free_cnt = 0;
    ROB_head_idx = 0; mispredict = 0; mispredict_idx = 0;
    m_tail = 0; m_rb_idx = 0; m_left = 0; m_st_cyc = 0; m_rb_cnt = 0;
    d_rst = 0; d_mis = 0; d_valid = 0; d_head = 0; d_midx = 0;
    full_res();
    repeat (2) @(posedge clock);

    // Reset state, then three back-to-back dispatches.
    step();
    d_valid = 2'b11;
    repeat (3) step();

    // Resource boundaries: one short blocks, exactly NUM_SUPER permits.
    d_fl = 8'd1; step();
    d_fl = 8'd2; step();
    d_fl = 8'd8; d_rob = 6'd1; step();
    d_rob = 6'd2; step();
    d_rob = 6'd8; d_rs = 8'd1; step();
    d_rs = 8'd8; d_valid = 2'b01; step();
    d_valid = 2'b11;

    // Advance tail to 30, then mispredict idx 12.
    repeat (10) step();
    d_mis = 1'b1; d_midx = 5'd12; step();
    repeat (4) step();

    // Nested mispredicts: older accepted, younger dropped.
    d_head = 5'd10;
    d_mis = 1'b1; d_midx = 5'd20; step();
    step();
    d_mis = 1'b1; d_midx = 5'd15; step();
    step();
    d_mis = 1'b1; d_midx = 5'd25; step();
    d_mis = 1'b1; d_midx = 5'd15; step();
    repeat (4) step();

    // Wrap: rollback to 30 puts tail at 31, next dispatch wraps.
    d_head = 5'd0;
    d_mis = 1'b1; d_midx = 5'd30; step();
    repeat (6) step();

    // Reset during the ROLLBACK cycle aborts recovery.
    d_mis = 1'b1; d_midx = 5'd7; step();
    d_rst = 1'b1; step();
    repeat (3) step();

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      d_valid = 2'($urandom_range(0, 3));
      d_rob   = 6'($urandom_range(0, 4));
      d_fl    = 8'($urandom_range(0, 4));
      d_rs    = 8'($urandom_range(0, 4));
      d_head  = 5'($urandom_range(0, 31));
      d_mis   = ($urandom_range(0, 7) == 0);
      d_midx  = 5'($urandom_range(0, 31));
      d_rst   = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
